// File: rtl/dispatch_ctrl_pkg.sv
// Shared types for the dispatch controller: instruction entry format,
// predecoded class bits, FSM state encoding and default constants.
package dispatch_ctrl_pkg;

  // Dispatch slots per cycle, equal to the instruction buffer output width
  localparam int ID_WIDTH = 2;

  // Default number of cycles dispatch stays blocked after a buffer flush
  localparam int FLUSH_HOLD_DEFAULT = 2;

  // Coarse operation kind carried with each buffered instruction
  typedef enum logic [3:0] {
    OP_ALU    = 4'd0,
    OP_LOAD   = 4'd1,
    OP_STORE  = 4'd2,
    OP_BRANCH = 4'd3,
    OP_CSR    = 4'd4,
    OP_ERTN   = 4'd5,
    OP_IDLE   = 4'd6,
    OP_TLB    = 4'd7,
    OP_BAR    = 4'd8
  } op_kind_t;

  // One instruction buffer entry
  typedef struct packed {
    logic        valid;
    op_kind_t    op;
    logic [31:0] pc;
    logic [31:0] instr;
  } instr_info_t;

  // Issue-relevant properties of an entry
  typedef struct packed {
    logic is_mem;
    logic is_branch;
    logic is_priv;
  } instr_class_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SER_PRE  = 2'd1,
    SER_POST = 2'd2,
    FLUSH    = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Buffer/ID-side bundle of the dispatch controller. The master modport is
// the dispatcher; the slave modport is the surrounding pipeline.
interface dispatch_ctrl_if;
  import dispatch_ctrl_pkg::*;

  instr_info_t         ib_instr_i [ID_WIDTH];
  logic [ID_WIDTH-1:0] ib_accept_o;
  logic                ib_flush_o;
  logic                redirect_i;
  logic                id_ready_i;
  logic                backend_empty_i;
  instr_info_t         id_instr_o [ID_WIDTH];

  modport master (
    input  ib_instr_i, redirect_i, id_ready_i, backend_empty_i,
    output ib_accept_o, ib_flush_o, id_instr_o
  );

  modport slave (
    output ib_instr_i, redirect_i, id_ready_i, backend_empty_i,
    input  ib_accept_o, ib_flush_o, id_instr_o
  );

endinterface

// File: rtl/dispatch_ctrl_predecode.sv
// instr_predecode: combinational classification of one buffer entry's
// operation kind into memory / branch / privileged (serializing) bits.
module instr_predecode
  import dispatch_ctrl_pkg::*;
(
  input  op_kind_t     op,
  output instr_class_t cls
);

  // Map the operation kind onto the class bits used by the issue rules
  always_comb begin
    cls           = '0;
    cls.is_mem    = (op == OP_LOAD) || (op == OP_STORE);
    cls.is_branch = (op == OP_BRANCH);
    cls.is_priv   = (op == OP_CSR) || (op == OP_ERTN) || (op == OP_IDLE) ||
                    (op == OP_TLB) || (op == OP_BAR);
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: decides each cycle how many in-order head entries of the
// instruction buffer to pop, registers them to the ID stage, flushes the
// buffer on a backend redirect and serializes privileged operations.
// Optional build macro: DISPATCH_PERF_CNT_EN adds stall/dual-issue counters.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int FLUSH_HOLD = FLUSH_HOLD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  dispatch_ctrl_if.master bus
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_o,
  output logic [31:0]     perf_dual_o
`endif
);

  localparam int              CNT_W     = $clog2(FLUSH_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(FLUSH_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);

  dispatch_state_t     state;
  logic [CNT_W-1:0]    hold_cnt;
  instr_class_t        cls [ID_WIDTH];
  logic [ID_WIDTH-1:0] accept;
  logic                head_valid;
  logic                id_group_valid;

  for (genvar g = 0; g < ID_WIDTH; g++) begin : g_predecode
    instr_predecode u_predecode (
      .op  (bus.ib_instr_i[g].op),
      .cls (cls[g])
    );
  end

  assign head_valid      = bus.ib_instr_i[0].valid;
  assign bus.ib_accept_o = accept;

  // Any entry still presented to ID; SER_POST waits for this to drain
  always_comb begin
    id_group_valid = 1'b0;
    for (int i = 0; i < ID_WIDTH; i++) begin
      id_group_valid = id_group_valid | bus.id_instr_o[i].valid;
    end
  end

  // Prefix-shaped pop mask: a slot pops only if every older slot pops too
  always_comb begin
    logic run;
    logic mem_seen;
    accept   = '0;
    run      = 1'b0;
    mem_seen = 1'b0;
    if (!bus.redirect_i) begin
      unique case (state)
        RUN: begin
          run = head_valid & bus.id_ready_i &
                (~cls[0].is_priv | bus.backend_empty_i);
          accept[0] = run;
          mem_seen  = cls[0].is_mem;
          for (int i = 1; i < ID_WIDTH; i++) begin
            run = run & bus.ib_instr_i[i].valid &
                  ~cls[i].is_priv & ~cls[i-1].is_priv &
                  ~cls[i-1].is_branch & ~(cls[i].is_mem & mem_seen);
            accept[i] = run;
            mem_seen  = mem_seen | cls[i].is_mem;
          end
        end
        SER_PRE: begin
          accept[0] = head_valid & bus.id_ready_i & bus.backend_empty_i;
        end
        default: begin
          accept = '0;
        end
      endcase
    end
  end

  // Dispatch FSM with registered ID group, flush pulse and flush hold count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      hold_cnt       <= '0;
      bus.ib_flush_o <= 1'b0;
      for (int i = 0; i < ID_WIDTH; i++) begin
        bus.id_instr_o[i] <= '0;
      end
    end else begin
      bus.ib_flush_o <= bus.redirect_i;
      if (bus.redirect_i) begin
        state    <= FLUSH;
        hold_cnt <= HOLD_LOAD;
        for (int i = 0; i < ID_WIDTH; i++) begin
          bus.id_instr_o[i] <= '0;
        end
      end else begin
        if (bus.id_ready_i) begin
          for (int i = 0; i < ID_WIDTH; i++) begin
            bus.id_instr_o[i] <= accept[i] ? bus.ib_instr_i[i] : '0;
          end
        end
        unique case (state)
          RUN: begin
            if (head_valid && cls[0].is_priv) begin
              if (accept[0]) begin
                state <= SER_POST;
              end else if (!bus.backend_empty_i) begin
                state <= SER_PRE;
              end
            end
          end
          SER_PRE: begin
            if (accept[0]) begin
              state <= SER_POST;
            end
          end
          SER_POST: begin
            if (bus.backend_empty_i && !id_group_valid) begin
              state <= RUN;
            end
          end
          FLUSH: begin
            if (hold_cnt <= HOLD_ONE) begin
              state    <= RUN;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt - HOLD_ONE;
            end
          end
          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  // Count zero-issue cycles with a valid head (outside FLUSH) and full-width issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_o <= '0;
      perf_dual_o  <= '0;
    end else begin
      if (head_valid && (accept == '0) && (state != FLUSH)) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
      if (&accept) begin
        perf_dual_o <= perf_dual_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Testbench for dispatch_ctrl: directed scenarios followed by randomized
// traffic, checked against a queue-based behavioural model of the buffer,
// the issue rules, serialization and flush hold.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dispatch_ctrl_if bus ();

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_dual;
`endif

  dispatch_ctrl #(.FLUSH_HOLD(FLUSH_HOLD_DEFAULT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DISPATCH_PERF_CNT_EN
    ,
    .perf_stall_o (perf_stall),
    .perf_dual_o  (perf_dual)
`endif
  );

  int          nChecks = 0;
  int          nFail   = 0;
  logic [31:0] pcSeq   = 32'h1000;

  // Behavioural model state
  instr_info_t ibq[$];
  instr_info_t expId [ID_WIDTH];
  logic        expFlush;
  bit          drainWait;
  bit          postWait;
  int          blockLeft;
  int          expStall;
  int          expDual;

  function automatic bit isPriv(instr_info_t e);
    return e.op inside {OP_CSR, OP_ERTN, OP_IDLE, OP_TLB, OP_BAR};
  endfunction

  function automatic bit isMem(instr_info_t e);
    return e.op inside {OP_LOAD, OP_STORE};
  endfunction

  function automatic bit isBranch(instr_info_t e);
    return e.op == OP_BRANCH;
  endfunction

  function automatic instr_info_t mkInstr(op_kind_t op);
    instr_info_t r;
    r.valid = 1'b1;
    r.op    = op;
    r.pc    = pcSeq;
    r.instr = $urandom;
    pcSeq   = pcSeq + 32'd4;
    return r;
  endfunction

  function automatic op_kind_t randOp();
    int r;
    r = $urandom_range(0, 15);
    if (r <= 5)       return OP_ALU;
    else if (r <= 7)  return OP_LOAD;
    else if (r <= 9)  return OP_STORE;
    else if (r <= 11) return OP_BRANCH;
    else if (r == 12) return OP_CSR;
    else if (r == 13) return OP_ERTN;
    else if (r == 14) return OP_TLB;
    else              return OP_BAR;
  endfunction

  task automatic resetModel();
    ibq.delete();
    for (int i = 0; i < ID_WIDTH; i++) expId[i] = '0;
    expFlush  = 1'b0;
    drainWait = 1'b0;
    postWait  = 1'b0;
    blockLeft = 0;
    expStall  = 0;
    expDual   = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: present buffer heads and controls, check the pop mask,
  // advance the model, then check the registered outputs after the edge.
  task automatic applyStimulus(input bit redirect, input bit idReady, input bit bEmpty,
                               output logic [ID_WIDTH-1:0] accSeen, output logic flushSeen);
    instr_info_t h [ID_WIDTH];
    int n;
    bit ok;
    bit memInGroup;
    bit anyIdValid;
    for (int i = 0; i < ID_WIDTH; i++) begin
      if (i < ibq.size()) h[i] = ibq[i];
      else                h[i] = '0;
      bus.ib_instr_i[i] = h[i];
    end
    bus.redirect_i      = redirect;
    bus.id_ready_i      = idReady;
    bus.backend_empty_i = bEmpty;

    n = 0;
    memInGroup = 1'b0;
    if (redirect || blockLeft > 0 || postWait) begin
      n = 0;
    end else if (drainWait) begin
      n = (bEmpty && idReady && h[0].valid) ? 1 : 0;
    end else begin
      for (int i = 0; i < ID_WIDTH; i++) begin
        if (i == 0)
          ok = h[0].valid && idReady && (!isPriv(h[0]) || bEmpty);
        else
          ok = h[i].valid && !isPriv(h[i]) && !isPriv(h[i-1]) &&
               !isBranch(h[i-1]) && !(isMem(h[i]) && memInGroup);
        if (!ok) break;
        n++;
        memInGroup = memInGroup | isMem(h[i]);
      end
    end

    @(negedge clk);
    accSeen = bus.ib_accept_o;
    checkOutput("accept", 128'(accSeen), 128'((1 << n) - 1));

    if (h[0].valid && n == 0 && blockLeft == 0) expStall++;
    if (n == ID_WIDTH) expDual++;

    anyIdValid = 1'b0;
    for (int i = 0; i < ID_WIDTH; i++) anyIdValid = anyIdValid | expId[i].valid;
    if (redirect) begin
      blockLeft = FLUSH_HOLD_DEFAULT;
      drainWait = 1'b0;
      postWait  = 1'b0;
      expFlush  = 1'b1;
      for (int i = 0; i < ID_WIDTH; i++) expId[i] = '0;
    end else begin
      expFlush = 1'b0;
      if (blockLeft > 0) begin
        blockLeft--;
      end else if (postWait) begin
        if (bEmpty && !anyIdValid) postWait = 1'b0;
      end else if (drainWait) begin
        if (n == 1) begin
          drainWait = 1'b0;
          postWait  = 1'b1;
        end
      end else if (h[0].valid && isPriv(h[0])) begin
        if (n > 0)        postWait  = 1'b1;
        else if (!bEmpty) drainWait = 1'b1;
      end
      if (idReady) begin
        for (int i = 0; i < ID_WIDTH; i++) begin
          if (i < n) expId[i] = h[i];
          else       expId[i] = '0;
        end
      end
    end

    @(posedge clk);
    #1;
    flushSeen = bus.ib_flush_o;
    checkOutput("ib_flush", 128'(flushSeen), 128'(expFlush));
    for (int i = 0; i < ID_WIDTH; i++)
      checkOutput($sformatf("id_instr[%0d]", i), 128'(bus.id_instr_o[i]), 128'(expId[i]));

    for (int k = 0; k < n; k++) void'(ibq.pop_front());
    if (expFlush) ibq.delete();
  endtask

  // Watchdog so the run always ends even if the clock loop misbehaves
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [ID_WIDTH-1:0] acc;
    logic                fl;
    logic [31:0]         savedPc;

    // Reset state
    for (int i = 0; i < ID_WIDTH; i++) bus.ib_instr_i[i] = '0;
    bus.redirect_i      = 1'b0;
    bus.id_ready_i      = 1'b0;
    bus.backend_empty_i = 1'b1;
    rst_n = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset id valid0", 128'(bus.id_instr_o[0].valid), 128'd0);
    checkOutput("reset id valid1", 128'(bus.id_instr_o[1].valid), 128'd0);
    checkOutput("reset flush", 128'(bus.ib_flush_o), 128'd0);
    checkOutput("reset accept", 128'(bus.ib_accept_o), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: two ALU ops issue together
    ibq.push_back(mkInstr(OP_ALU));
    ibq.push_back(mkInstr(OP_ALU));
    applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
    checkOutput("T1 accept", 128'(acc), 128'd3);

    // T2: load then store split into two groups
    ibq.push_back(mkInstr(OP_LOAD));
    ibq.push_back(mkInstr(OP_STORE));
    applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
    checkOutput("T2 accept ld", 128'(acc), 128'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
    checkOutput("T2 accept st", 128'(acc), 128'd1);

    // T3: CSR waits for the backend to drain, issues alone, then drains again
    ibq.push_back(mkInstr(OP_CSR));
    ibq.push_back(mkInstr(OP_ALU));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, acc, fl);
      checkOutput("T3 accept pre", 128'(acc), 128'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
    checkOutput("T3 accept csr", 128'(acc), 128'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, acc, fl);
    checkOutput("T3 accept post", 128'(acc), 128'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
    checkOutput("T3 accept post exit", 128'(acc), 128'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
    checkOutput("T3 accept resume", 128'(acc), 128'd1);

    // T4: redirect flushes and blocks dispatch for the hold period
    repeat (4) ibq.push_back(mkInstr(OP_ALU));
    applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
    applyStimulus(1'b1, 1'b1, 1'b1, acc, fl);
    checkOutput("T4 accept redirect", 128'(acc), 128'd0);
    checkOutput("T4 flush pulse", 128'(fl), 128'd1);
    checkOutput("T4 id cleared", 128'(bus.id_instr_o[0].valid), 128'd0);
    ibq.push_back(mkInstr(OP_ALU));
    ibq.push_back(mkInstr(OP_ALU));
    for (int k = 0; k < FLUSH_HOLD_DEFAULT; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
      checkOutput("T4 accept hold", 128'(acc), 128'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
    checkOutput("T4 accept resume", 128'(acc), 128'd3);

    // T5: ID not ready holds the registered group
    ibq.push_back(mkInstr(OP_ALU));
    ibq.push_back(mkInstr(OP_ALU));
    savedPc = ibq[1].pc;
    applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
    ibq.push_back(mkInstr(OP_ALU));
    ibq.push_back(mkInstr(OP_ALU));
    applyStimulus(1'b0, 1'b0, 1'b1, acc, fl);
    checkOutput("T5 accept", 128'(acc), 128'd0);
    checkOutput("T5 hold pc", 128'(bus.id_instr_o[1].pc), 128'(savedPc));
    applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);

    // Branch ends a group; privileged op never pairs behind another op
    ibq.push_back(mkInstr(OP_BRANCH));
    ibq.push_back(mkInstr(OP_ALU));
    applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
    checkOutput("branch accept", 128'(acc), 128'd1);
    ibq.push_back(mkInstr(OP_CSR));
    applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
    checkOutput("alu+csr accept", 128'(acc), 128'd1);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);

    // Asynchronous reset in the middle of a redirect: no flush pulse
    ibq.push_back(mkInstr(OP_ALU));
    ibq.push_back(mkInstr(OP_ALU));
    applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
    bus.redirect_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset id", 128'(bus.id_instr_o[0].valid), 128'd0);
    checkOutput("async reset flush", 128'(bus.ib_flush_o), 128'd0);
    @(negedge clk);
    bus.redirect_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post reset flush", 128'(bus.ib_flush_o), 128'd0);
    resetModel();

`ifdef DISPATCH_PERF_CNT_EN
    // T6: five stalled cycles then three dual-issue cycles
    repeat (6) ibq.push_back(mkInstr(OP_ALU));
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, acc, fl);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, acc, fl);
    #1;
    checkOutput("T6 perf_stall", 128'(perf_stall), 128'd5);
    checkOutput("T6 perf_dual", 128'(perf_dual), 128'd3);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      int target;
      target = $urandom_range(0, 4);
      while (ibq.size() < target) ibq.push_back(mkInstr(randOp()));
      applyStimulus(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 1) == 1), acc, fl);
    end

`ifdef DISPATCH_PERF_CNT_EN
    checkOutput("perf_stall total", 128'(perf_stall), 128'(expStall));
    checkOutput("perf_dual total", 128'(perf_dual), 128'(expDual));
`endif

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
